// File: rtl/display_req_arbiter.sv
// display_req_arbiter
// Shares one display formatter among NUM_REQ requesters. It picks a winner,
// launches the formatter with a one-cycle disp_en and follows disp_busy
// through its rise and fall. It then returns a one-cycle completion pulse to
// the requester that was served. A watchdog ends a transfer whose busy flag
// never rises or never falls, and it sets the sticky timeout_err flag.
// Optional build macro: DISP_ARB_FIXED_PRIO_EN
//   - undefined (default): round-robin starting at rr_ptr
//   - defined: fixed priority, lowest index wins, no rr_ptr
module display_req_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 32,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*2-1:0]       req_fmt,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [DATA_W-1:0]          disp_data,
  output logic [1:0]                 disp_fmt,
  output logic                       disp_en,
  input  logic                       disp_busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  // The counter is cleared in ISSUE and counts the wait cycles that follow.
  // The expiry decision is registered, so firing on BUSY_TIMEOUT-1 places
  // the done pulse exactly BUSY_TIMEOUT cycles after the ISSUE cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          fmt_q, fmt_d;
  logic                en_q, en_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                terr_q, terr_d;
`ifndef DISP_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

  logic                win_found_s;
  logic [ID_W-1:0]     win_id_s;
  logic [ID_W-1:0]     cand_s;
  logic [DATA_W-1:0]   data_arr_s [NUM_REQ];
  logic [1:0]          fmt_arr_s  [NUM_REQ];

  // Unpack the flat request buses into per-requester views
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr_s[g] = req_data[g*DATA_W +: DATA_W];
    assign fmt_arr_s[g]  = req_fmt[g*2 +: 2];
  end

  // Search for the first active request from the starting index, wrapping
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef DISP_ARB_FIXED_PRIO_EN
      cand_s = ID_W'(i);
`else
      cand_s = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
`endif
      if (req[cand_s] && !win_found_s) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state, watchdog and output computation for the transfer sequence
  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    done_d   = '0;
    en_d     = 1'b0;
    data_d   = data_q;
    fmt_d    = fmt_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    terr_d   = terr_q;
`ifndef DISP_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found_s && !disp_busy) begin
          state_d  = ISSUE;
          gnt_d    = NUM_REQ'(1) << win_id_s;
          en_d     = 1'b1;
          data_d   = data_arr_s[win_id_s];
          fmt_d    = fmt_arr_s[win_id_s];
          id_d     = win_id_s;
`ifndef DISP_ARB_FIXED_PRIO_EN
          rr_ptr_d = (win_id_s == ID_MAX) ? '0 : win_id_s + ID_W'(1);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_LAST) begin
          state_d = IDLE;
          done_d  = NUM_REQ'(1) << id_q;
          terr_d  = 1'b1;
        end else if (disp_busy) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!disp_busy) begin
          state_d = IDLE;
          done_d  = NUM_REQ'(1) << id_q;
        end else if (cnt_d == CNT_LAST) begin
          state_d = IDLE;
          done_d  = NUM_REQ'(1) << id_q;
          terr_d  = 1'b1;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register state and every output; reset drops any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      data_q   <= '0;
      fmt_q    <= 2'b00;
      en_q     <= 1'b0;
      id_q     <= '0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
`ifndef DISP_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      data_q   <= data_d;
      fmt_q    <= fmt_d;
      en_q     <= en_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
`ifndef DISP_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign disp_data   = data_q;
  assign disp_fmt    = fmt_q;
  assign disp_en     = en_q;
  assign active_id   = id_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_display_req_arbiter.sv
// Self-checking bench for display_req_arbiter: a transaction-level model
// predicts each grant when the requests are raised. A monitor compares every
// gnt/done against the queued predictions. A behavioural formatter drives disp_busy.
module tb_display_req_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int M_RAND  = 0;
  localparam int M_FIXED = 1;
  localparam int M_NEVER = 2;
  localparam int LIMIT   = 100;

  typedef struct {
    int           id;
    logic [DW-1:0] data;
    logic [1:0]   fmt;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR*2-1:0]   req_fmt;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic [DW-1:0]     disp_data;
  logic [1:0]        disp_fmt;
  logic              disp_en;
  logic              disp_busy;
  logic [1:0]        active_id;
  logic              timeout_err;

  logic              fmt_busy;
  logic              ext_busy;
  int                fmt_mode;
  int                fmt_d1;
  int                fmt_d2;

  int                n_vec;
  int                n_mis;
  int                mdl_ptr;
  logic [DW-1:0]     dat_a [NR];
  logic [1:0]        fm_a  [NR];
  exp_t              exp_gnt_q [$];
  int                exp_done_q [$];
  logic              in_flight;

  assign disp_busy = fmt_busy | ext_busy;

  display_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_fmt(req_fmt),
    .gnt(gnt), .done(done), .disp_data(disp_data), .disp_fmt(disp_fmt),
    .disp_en(disp_en), .disp_busy(disp_busy), .active_id(active_id),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_vec++;
    n_mis++;
    $display("FAIL %s: got 0x%0h, nothing expected / bound expired", name, act);
  endtask

  function automatic logic [NR-1:0] onehot(input int id);
    logic [NR-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Winner rule: round-robin from the model pointer, or lowest index
  function automatic int pick(input logic [NR-1:0] p, input int ptr);
`ifdef DISP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (p[i]) return i;
`else
    for (int k = 0; k < NR; k++) if (p[(ptr + k) % NR]) return (ptr + k) % NR;
`endif
    return -1;
  endfunction

  task automatic raise(input int i, input logic [DW-1:0] d, input logic [1:0] f);
    req[i] = 1'b1;
    dat_a[i] = d;
    fm_a[i] = f;
    req_data[i*DW +: DW] = d;
    req_fmt[i*2 +: 2] = f;
  endtask

  task automatic raise_set(input logic [NR-1:0] m);
    for (int i = 0; i < NR; i++)
      if (m[i]) raise(i, $urandom, 2'($urandom_range(0, 3)));
  endtask

  task automatic push_next(output int w);
    exp_t e;
    w = pick(req, mdl_ptr);
    e.id = w;
    e.data = dat_a[w];
    e.fmt = fm_a[w];
    exp_gnt_q.push_back(e);
    mdl_ptr = (w + 1) % NR;
  endtask

  task automatic wait_gnt(output int cyc, output bit ok);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == '0 && cyc < LIMIT);
    ok = (gnt != '0);
    if (!ok) fail_now("gnt_wait_bound", 64'(cyc));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done == '0 && cyc < LIMIT);
    if (done == '0) fail_now("done_wait_bound", 64'(cyc));
  endtask

  task automatic wait_quiet();
    int c;
    c = 0;
    while ((exp_gnt_q.size() != 0 || exp_done_q.size() != 0) && c < 4 * LIMIT) begin
      @(negedge clk);
      c++;
    end
    if (exp_gnt_q.size() != 0 || exp_done_q.size() != 0)
      fail_now("drain_bound", 64'(exp_gnt_q.size() + exp_done_q.size()));
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_ptr = 0;
    exp_gnt_q.delete();
    exp_done_q.delete();
  endtask

  // Requesters raise new work each time a grant appears, keeping the pending
  // set known at the moment the next arbitration happens.
  task automatic run_chain(input int steps, input logic [NR-1:0] mask, input bit rnd);
    int cyc, last, s;
    bit ok;
    logic [NR-1:0] m;
    @(negedge clk);
    if (rnd) m = NR'($urandom_range(1, (1 << NR) - 1));
    else m = mask;
    raise_set(m);
    push_next(last);
    s = 0;
    while (req != '0) begin
      wait_gnt(cyc, ok);
      if (!ok) return;
      req[last] = 1'b0;
      s++;
      if (s < steps) begin
        if (rnd) m = NR'($urandom_range(0, (1 << NR) - 1)) & ~req;
        else m = mask & ~req;
        if (m == '0 && req == '0) m = onehot($urandom_range(0, NR - 1));
        raise_set(m);
      end
      if (req != '0) push_next(last);
    end
    wait_quiet();
  endtask

  // Formatter: after disp_en, raise busy after d1 cycles and hold it d2 cycles
  initial begin
    int d1, d2;
    fmt_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (disp_en === 1'b1 && fmt_mode != M_NEVER) begin
        if (fmt_mode == M_RAND) begin
          d1 = $urandom_range(1, 3);
          d2 = $urandom_range(1, 4);
        end else begin
          d1 = fmt_d1;
          d2 = fmt_d2;
        end
        repeat (d1) @(negedge clk);
        fmt_busy = 1'b1;
        repeat (d2) @(negedge clk);
        fmt_busy = 1'b0;
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a grant or completion
  initial begin
    exp_t e;
    int id;
    in_flight = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_flight = 1'b0;
      end else begin
        if (gnt != '0 || disp_en) begin
          check("no_overlap", 64'(in_flight), 64'(0));
          if (exp_gnt_q.size() == 0) begin
            fail_now("unexpected_gnt", 64'(gnt));
          end else begin
            e = exp_gnt_q.pop_front();
            check("gnt_id", 64'(gnt), 64'(onehot(e.id)));
            check("disp_en_with_gnt", 64'(disp_en), 64'(1));
            check("disp_data", 64'(disp_data), 64'(e.data));
            check("disp_fmt", 64'(disp_fmt), 64'(e.fmt));
            check("active_id", 64'(active_id), 64'(e.id));
            exp_done_q.push_back(e.id);
          end
          in_flight = 1'b1;
        end
        if (done != '0) begin
          if (exp_done_q.size() == 0) begin
            fail_now("unexpected_done", 64'(done));
          end else begin
            id = exp_done_q.pop_front();
            check("done_id", 64'(done), 64'(onehot(id)));
          end
          in_flight = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, last;
    bit ok;
    n_vec = 0;
    n_mis = 0;
    mdl_ptr = 0;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    req_fmt = '0;
    ext_busy = 1'b0;
    fmt_mode = M_FIXED;
    fmt_d1 = 1;
    fmt_d2 = 3;
    for (int i = 0; i < NR; i++) begin
      dat_a[i] = '0;
      fm_a[i] = 2'b00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_disp_en", 64'(disp_en), 64'(0));
    check("rst_disp_data", 64'(disp_data), 64'(0));
    check("rst_disp_fmt", 64'(disp_fmt), 64'(0));
    check("rst_active_id", 64'(active_id), 64'(0));
    check("rst_timeout_err", 64'(timeout_err), 64'(0));
    rst = 1'b0;

    // Single request, busy high for 3 cycles
    @(negedge clk);
    raise(0, 32'hDEADBEEF, 2'b00);
    push_next(last);
    wait_gnt(cyc, ok);
    check("single_gnt_latency", 64'(cyc), 64'(1));
    req[0] = 1'b0;
    wait_done(cyc);
    check("single_done_latency", 64'(cyc), 64'(fmt_d1 + fmt_d2 + 1));

    // Formatter busy at request time blocks arbitration
    @(negedge clk);
    ext_busy = 1'b1;
    repeat (2) @(negedge clk);
    raise(2, $urandom, 2'b10);
    repeat (4) @(negedge clk);
    check("busy_blocks_gnt", 64'(gnt), 64'(0));
    ext_busy = 1'b0;
    push_next(last);
    wait_gnt(cyc, ok);
    check("busy_release_gnt_latency", 64'(cyc), 64'(1));
    req[2] = 1'b0;
    wait_done(cyc);

    // Timeout: formatter never asserts busy
    @(negedge clk);
    fmt_mode = M_NEVER;
    raise(1, $urandom, 2'b01);
    push_next(last);
    wait_gnt(cyc, ok);
    req[1] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == TMO - 1) check("timeout_err_before", 64'(timeout_err), 64'(0));
    end while (done == '0 && cyc < LIMIT);
    check("timeout_done_latency", 64'(cyc), 64'(TMO));
    check("timeout_err_set", 64'(timeout_err), 64'(1));

    // Timeout: busy rises and never falls; arbitration then waits for busy
    @(negedge clk);
    raise(3, $urandom, 2'b11);
    push_next(last);
    wait_gnt(cyc, ok);
    req[3] = 1'b0;
    @(negedge clk);
    ext_busy = 1'b1;
    wait_done(cyc);
    check("stuck_done_latency", 64'(cyc + 1), 64'(TMO));
    raise(0, $urandom, 2'b01);
    repeat (3) @(negedge clk);
    check("stuck_busy_blocks_gnt", 64'(gnt), 64'(0));
    fmt_mode = M_FIXED;
    ext_busy = 1'b0;
    push_next(last);
    wait_gnt(cyc, ok);
    check("stuck_release_gnt_latency", 64'(cyc), 64'(1));
    req[0] = 1'b0;
    wait_done(cyc);
    check("timeout_err_sticky", 64'(timeout_err), 64'(1));

    // Reset in WAIT_DONE drops the transfer without a done pulse
    @(negedge clk);
    fmt_d1 = 1;
    fmt_d2 = 8;
    raise(2, $urandom, 2'b00);
    push_next(last);
    wait_gnt(cyc, ok);
    req[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_gnt", 64'(gnt), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_disp_en", 64'(disp_en), 64'(0));
    check("mid_rst_disp_data", 64'(disp_data), 64'(0));
    check("mid_rst_active_id", 64'(active_id), 64'(0));
    check("mid_rst_timeout_err", 64'(timeout_err), 64'(0));
    rst = 1'b0;
    mdl_ptr = 0;
    exp_done_q.delete();
    cyc = 0;
    while (disp_busy && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 64'(exp_done_q.size()), 64'(0));
    raise(1, $urandom, 2'b10);
    push_next(last);
    wait_gnt(cyc, ok);
    check("post_rst_gnt_latency", 64'(cyc), 64'(1));
    req[1] = 1'b0;
    wait_done(cyc);
    fmt_d2 = 3;

    // All four requesters held: round-robin order from pointer 0
    apply_reset();
    run_chain(5, 4'b1111, 1'b0);

    // Requesters 1 and 3 held (lowest index always wins in fixed priority)
    run_chain(4, 4'b1010, 1'b0);

    // Randomised request sets and formatter timing
    fmt_mode = M_RAND;
    run_chain(60, 4'b0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
